// File: rtl/issue_slot_ctrl.sv
// Slot allocator and issue sequencer for an age-ordered issue queue.
// Define ISSUE_SLOT_CTRL_STALL_CNT_EN to build the full-stall counter.
module issue_slot_ctrl #(
  parameter int EntryCount = 4,
  parameter int EnqWidth   = 2,
  parameter int SelWidth   = 2,
  localparam int IdxW      = $clog2(EntryCount)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic [EnqWidth-1:0]            enq_vld_i,
  input  logic [EnqWidth-1:0]            enq_opr_rdy_i,
  output logic [EnqWidth-1:0]            enq_rdy_o,
  output logic [EnqWidth*IdxW-1:0]       enq_idx_o,
  input  logic [EntryCount-1:0]          wakeup_i,
  output logic [EnqWidth-1:0]            sel_enq_fire_o,
  output logic [EnqWidth*EntryCount-1:0] sel_enq_mask_o,
  output logic                           sel_deq_fire_o,
  output logic [EntryCount-1:0]          sel_deq_mask_o,
  output logic [EntryCount-1:0]          sel_mask_o,
  output logic [EntryCount-1:0]          entry_vld_o,
  input  logic [SelWidth*EntryCount-1:0] sel_result_i,
  output logic [SelWidth-1:0]            iss_vld_o,
  output logic [SelWidth*IdxW-1:0]       iss_idx_o,
  input  logic [SelWidth-1:0]            iss_rdy_i,
  output logic [IdxW:0]                  occupancy_o,
  output logic [15:0]                    stall_cnt_o
);

  logic [EntryCount-1:0] entry_vld;
  logic [EntryCount-1:0] entry_rdy;
  logic [IdxW:0]         occupancy;

  logic [EntryCount-1:0] claimed;
  logic                  chain;
  logic                  found;
  logic [IdxW-1:0]       pick;
  logic [IdxW-1:0]       slot;
  logic [EntryCount-1:0] vld_nxt;
  logic [EntryCount-1:0] rdy_nxt;
  logic [IdxW:0]         occ_nxt;

  function automatic logic [IdxW:0] cnt_ones(
    input logic [EntryCount-1:0] v
  );
    logic [IdxW:0] c;
    c = '0;
    for (int k = 0; k < EntryCount; k++)
      c = c + (IdxW+1)'(v[k]);
    return c;
  endfunction

  assign entry_vld_o = entry_vld;
  assign occupancy_o = occupancy;
  assign sel_mask_o  = flush_i ? '0
                     : (entry_vld & entry_rdy);

  // A refused port holds back every later port to keep enqueue in order.
  always_comb begin
    claimed        = '0;
    chain          = ~rst & ~flush_i;
    found          = 1'b0;
    pick           = '0;
    enq_rdy_o      = '0;
    enq_idx_o      = '0;
    sel_enq_mask_o = '0;
    for (int j = 0; j < EnqWidth; j++) begin
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < EntryCount; k++) begin
        if (!found && !entry_vld[k] && !claimed[k]) begin
          found = 1'b1;
          pick  = IdxW'(k);
        end
      end
      chain        = chain & found;
      enq_rdy_o[j] = chain;
      if (chain) begin
        claimed[pick] = 1'b1;
        enq_idx_o[j*IdxW +: IdxW] = pick;
        sel_enq_mask_o[j*EntryCount + int'(pick)] = 1'b1;
      end
    end
  end

  assign sel_enq_fire_o = enq_vld_i & enq_rdy_o;

  always_comb begin
    iss_vld_o      = '0;
    iss_idx_o      = '0;
    sel_deq_mask_o = '0;
    for (int i = 0; i < SelWidth; i++) begin
      iss_vld_o[i] = (|sel_result_i[i*EntryCount +: EntryCount])
                   & ~flush_i;
      for (int k = 0; k < EntryCount; k++) begin
        if (sel_result_i[i*EntryCount + k])
          iss_idx_o[i*IdxW +: IdxW] = IdxW'(k);
      end
      if (iss_vld_o[i] && iss_rdy_i[i])
        sel_deq_mask_o = sel_deq_mask_o
                       | sel_result_i[i*EntryCount +: EntryCount];
    end
  end

  assign sel_deq_fire_o = |sel_deq_mask_o;

  // Issue beats a same-cycle wakeup: the cleared slot stays free.
  always_comb begin
    slot    = '0;
    vld_nxt = entry_vld & ~sel_deq_mask_o;
    rdy_nxt = (entry_rdy | (wakeup_i & entry_vld))
            & ~sel_deq_mask_o;
    for (int j = 0; j < EnqWidth; j++) begin
      slot = enq_idx_o[j*IdxW +: IdxW];
      if (sel_enq_fire_o[j]) begin
        vld_nxt[slot] = 1'b1;
        rdy_nxt[slot] = enq_opr_rdy_i[j];
      end
    end
    occ_nxt = occupancy
            + cnt_ones(EntryCount'(sel_enq_fire_o))
            - cnt_ones(sel_deq_mask_o);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      entry_vld <= '0;
      entry_rdy <= '0;
      occupancy <= '0;
    end else begin
      entry_vld <= vld_nxt;
      entry_rdy <= rdy_nxt;
      occupancy <= occ_nxt;
    end
  end

`ifdef ISSUE_SLOT_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || flush_i)
      stall_cnt <= '0;
    else if ((|enq_vld_i) && !enq_rdy_o[0]
             && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

  function automatic logic results_ok(
    input logic [SelWidth*EntryCount-1:0] res,
    input logic [EntryCount-1:0]          cand
  );
    logic [EntryCount-1:0] seen;
    logic [EntryCount-1:0] r;
    logic                  ok;
    seen = '0;
    ok   = 1'b1;
    for (int i = 0; i < SelWidth; i++) begin
      r = res[i*EntryCount +: EntryCount];
      if (!$onehot0(r))        ok = 1'b0;
      if ((r & ~cand) != '0)   ok = 1'b0;
      if ((r & seen) != '0)    ok = 1'b0;
      seen = seen | r;
    end
    return ok;
  endfunction

  a_sel_legal: assert property (
    @(posedge clk) disable iff (rst || flush_i)
    results_ok(sel_result_i, sel_mask_o));

  a_occ_match: assert property (
    @(posedge clk) disable iff (rst)
    occupancy_o == cnt_ones(entry_vld_o));

endmodule

// File: tb/tb_issue_slot_ctrl.sv
// Bench for issue_slot_ctrl: directed scenarios then random traffic
// checked against a slot-list reference model.
module tb_issue_slot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [1:0]  enq_vld_i;
  logic [1:0]  enq_opr_rdy_i;
  logic [1:0]  enq_rdy_o;
  logic [3:0]  enq_idx_o;
  logic [3:0]  wakeup_i;
  logic [1:0]  sel_enq_fire_o;
  logic [7:0]  sel_enq_mask_o;
  logic        sel_deq_fire_o;
  logic [3:0]  sel_deq_mask_o;
  logic [3:0]  sel_mask_o;
  logic [3:0]  entry_vld_o;
  logic [7:0]  sel_result_i;
  logic [1:0]  iss_vld_o;
  logic [3:0]  iss_idx_o;
  logic [1:0]  iss_rdy_i;
  logic [2:0]  occupancy_o;
  logic [15:0] stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] mvld = '0;
  logic [3:0] mrdy = '0;
  int         mstall = 0;

  always #5 clk = ~clk;

  issue_slot_ctrl #(
    .EntryCount(4), .EnqWidth(2), .SelWidth(2)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_vld_i(enq_vld_i), .enq_opr_rdy_i(enq_opr_rdy_i),
    .enq_rdy_o(enq_rdy_o), .enq_idx_o(enq_idx_o),
    .wakeup_i(wakeup_i), .sel_enq_fire_o(sel_enq_fire_o),
    .sel_enq_mask_o(sel_enq_mask_o),
    .sel_deq_fire_o(sel_deq_fire_o),
    .sel_deq_mask_o(sel_deq_mask_o), .sel_mask_o(sel_mask_o),
    .entry_vld_o(entry_vld_o), .sel_result_i(sel_result_i),
    .iss_vld_o(iss_vld_o), .iss_idx_o(iss_idx_o),
    .iss_rdy_i(iss_rdy_i), .occupancy_o(occupancy_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pick1(input logic [3:0] cand);
    int         q[$];
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 0; k < 4; k++)
      if (cand[k]) q.push_back(k);
    if (q.size() == 0 || $urandom_range(0, 3) == 0)
      return 4'b0000;
    return one << q[$urandom_range(0, q.size() - 1)];
  endfunction

  // One clock: drive, check combinational outputs, clock, check state.
  task automatic step(input logic fl, input logic [1:0] ev,
                      input logic [1:0] eo, input logic [3:0] wk,
                      input logic [3:0] r0, input logic [3:0] r1,
                      input logic [1:0] ir);
    int         free_q[$];
    logic [1:0] e_rdy;
    logic [3:0] e_idx;
    logic [7:0] e_emask;
    logic [3:0] e_sel;
    logic [1:0] e_iv;
    logic [3:0] e_ii;
    logic [3:0] e_deq;
    logic [3:0] res [2];
    logic [3:0] fired;
    @(negedge clk);
    flush_i       = fl;
    enq_vld_i     = ev;
    enq_opr_rdy_i = eo;
    wakeup_i      = wk;
    sel_result_i  = {r1, r0};
    iss_rdy_i     = ir;
    #1;
    res[0] = r0;
    res[1] = r1;
    e_rdy = '0; e_idx = '0; e_emask = '0;
    e_iv = '0; e_ii = '0; e_deq = '0;
    for (int k = 0; k < 4; k++)
      if (!mvld[k]) free_q.push_back(k);
    for (int j = 0; j < 2; j++) begin
      if (!fl && j < free_q.size()) begin
        e_rdy[j] = 1'b1;
        e_idx[j*2 +: 2] = 2'(free_q[j]);
        e_emask[j*4 + free_q[j]] = 1'b1;
      end
    end
    e_sel = fl ? 4'b0000 : (mvld & mrdy);
    for (int i = 0; i < 2; i++) begin
      e_iv[i] = !fl && res[i] != 4'b0000;
      for (int k = 0; k < 4; k++)
        if (res[i][k]) e_ii[i*2 +: 2] = 2'(k);
      if (e_iv[i] && ir[i]) e_deq = e_deq | res[i];
    end
    chk("enq_rdy", 32'(enq_rdy_o), 32'(e_rdy));
    chk("enq_idx", 32'(enq_idx_o), 32'(e_idx));
    chk("enq_mask", 32'(sel_enq_mask_o), 32'(e_emask));
    chk("enq_fire", 32'(sel_enq_fire_o), 32'(ev & e_rdy));
    chk("sel_mask", 32'(sel_mask_o), 32'(e_sel));
    chk("iss_vld", 32'(iss_vld_o), 32'(e_iv));
    chk("iss_idx", 32'(iss_idx_o), 32'(e_ii));
    chk("deq_mask", 32'(sel_deq_mask_o), 32'(e_deq));
    chk("deq_fire", 32'(sel_deq_fire_o), 32'(e_deq != 4'b0000));
    if (fl) begin
      mvld = '0;
      mrdy = '0;
      mstall = 0;
    end else begin
      if (ev != 2'b00 && !e_rdy[0] && mstall < 16'hFFFF)
        mstall++;
      fired = e_deq;
      mvld  = mvld & ~fired;
      mrdy  = (mrdy | (wk & mvld)) & ~fired;
      for (int j = 0; j < 2; j++) begin
        if (ev[j] && e_rdy[j]) begin
          mvld[free_q[j]] = 1'b1;
          mrdy[free_q[j]] = eo[j];
        end
      end
    end
    @(posedge clk);
    #1;
    chk("entry_vld", 32'(entry_vld_o), 32'(mvld));
    chk("occupancy", 32'(occupancy_o), 32'($countones(mvld)));
`ifdef ISSUE_SLOT_CTRL_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt_o), 32'(mstall));
`else
    chk("stall_cnt", 32'(stall_cnt_o), 32'd0);
`endif
  endtask

  initial begin
    logic       fl;
    logic [3:0] cand;
    logic [3:0] r0;
    logic [3:0] r1;
    rst = 1'b1; flush_i = 1'b0;
    enq_vld_i = 2'b11; enq_opr_rdy_i = 2'b00;
    wakeup_i = '0; sel_result_i = '0; iss_rdy_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_enq_rdy", 32'(enq_rdy_o), 32'd0);
    chk("rst_vld", 32'(entry_vld_o), 32'd0);
    chk("rst_occ", 32'(occupancy_o), 32'd0);
    chk("rst_stall", 32'(stall_cnt_o), 32'd0);
    chk("rst_sel", 32'(sel_mask_o), 32'd0);
    rst = 1'b0;
    enq_vld_i = 2'b00;

    step(0, 2'b11, 2'b11, 4'h0, 4'h0, 4'h0, 2'b00);
    chk("t1_vld", 32'(entry_vld_o), 32'h3);
    chk("t1_occ", 32'(occupancy_o), 32'd2);
    step(0, 2'b11, 2'b11, 4'h0, 4'h0, 4'h0, 2'b00);
    repeat (3) step(0, 2'b01, 2'b01, 4'h0, 4'h0, 4'h0, 2'b00);
`ifdef ISSUE_SLOT_CTRL_STALL_CNT_EN
    chk("t2_stall", 32'(stall_cnt_o), 32'd3);
`endif
    step(0, 2'b00, 2'b00, 4'h0, 4'b0001, 4'b0010, 2'b01);
    chk("t3_vld", 32'(entry_vld_o), 32'hE);
    step(0, 2'b01, 2'b01, 4'h0, 4'h0, 4'h0, 2'b00);
    step(0, 2'b01, 2'b01, 4'h0, 4'b0001, 4'h0, 2'b01);
    step(0, 2'b01, 2'b01, 4'h0, 4'h0, 4'h0, 2'b00);
    chk("t5_vld", 32'(entry_vld_o), 32'hF);
    step(0, 2'b00, 2'b00, 4'h0, 4'b0001, 4'h0, 2'b01);
    step(1, 2'b01, 2'b01, 4'h0, 4'b0010, 4'h0, 2'b01);
    chk("t6_vld", 32'(entry_vld_o), 32'h0);
    chk("t6_occ", 32'(occupancy_o), 32'd0);
    step(0, 2'b11, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00);
    step(0, 2'b01, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00);
    step(0, 2'b00, 2'b00, 4'b0100, 4'h0, 4'h0, 2'b00);
    chk("t4_sel2", 32'(sel_mask_o[2]), 32'd1);

    for (int n = 0; n < 400; n++) begin
      fl   = ($urandom_range(0, 24) == 0);
      cand = mvld & mrdy;
      r0   = pick1(cand);
      r1   = pick1(cand & ~r0);
      step(fl, 2'($urandom), 2'($urandom),
           4'($urandom) & 4'($urandom), r0, r1, 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
